// File: rtl/wb_sram_arb_pkg.sv
// ============================================================================
// Module      : wb_sram_arb_pkg
// Description : Shared types and helpers for the two-master Wishbone SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } arb_state_e;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned nb_of(input int unsigned data_width);
        return data_width / BYTE_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_rr_arb2.sv
// ============================================================================
// Module      : wb_rr_arb2
// Description : Combinational two-requester round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // On a tie the requester not served last wins.
    assign gnt_valid = |req;
    assign gnt_idx   = (&req) ? ~last : req[1];

endmodule

`default_nettype wire

// File: rtl/wb_sram_arbiter_2m.sv
// ============================================================================
// Module      : wb_sram_arbiter_2m
// Description : Round-robin two-master Wishbone arbiter driving one synchronous
//               byte-enable SRAM. Optional macro WB_SRAM_ARB_BURST_EN holds the
//               grant while the granted master keeps cyc asserted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_sram_arbiter_2m
    import wb_sram_arb_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int NB         = nb_of(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_adr,
    input  logic [NB-1:0]         m0_sel,
    input  logic [DATA_WIDTH-1:0] m0_dat_w,
    output logic [DATA_WIDTH-1:0] m0_dat_r,
    output logic                  m0_ack,
    output logic                  m0_err,

    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_adr,
    input  logic [NB-1:0]         m1_sel,
    input  logic [DATA_WIDTH-1:0] m1_dat_w,
    output logic [DATA_WIDTH-1:0] m1_dat_r,
    output logic                  m1_ack,
    output logic                  m1_err,

    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_read_en,
    output logic                  sram_write_en,
    output logic [NB-1:0]         sram_byte_en,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    input  logic [DATA_WIDTH-1:0] sram_read_data
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q,  last_d;
`ifdef WB_SRAM_ARB_BURST_EN
    logic       held_q,  held_d;
    logic       g_cyc;
`endif

    logic                  gnt_valid, gnt_idx;
    logic                  g_req, g_we;
    logic [NB-1:0]         g_sel;
    logic                  ack, rd_en, wr_en, done;

    wb_rr_arb2 u_rr (
        .req       ({m1_cyc & m1_stb, m0_cyc & m0_stb}),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Only the granted master's signals ever reach the SRAM.
    assign g_req           = grant_q ? (m1_cyc & m1_stb) : (m0_cyc & m0_stb);
    assign g_we            = grant_q ? m1_we  : m0_we;
    assign g_sel           = grant_q ? m1_sel : m0_sel;
    assign sram_addr       = grant_q ? m1_adr : m0_adr;
    assign sram_write_data = grant_q ? m1_dat_w : m0_dat_w;
    assign sram_byte_en    = g_sel;
`ifdef WB_SRAM_ARB_BURST_EN
    assign g_cyc           = grant_q ? m1_cyc : m0_cyc;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        ack     = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        done    = 1'b0;
`ifdef WB_SRAM_ARB_BURST_EN
        held_d  = held_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d = gnt_idx;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!g_req) begin
`ifdef WB_SRAM_ARB_BURST_EN
                    // cyc high with stb low keeps the burst parked here.
                    if (!g_cyc) begin
                        state_d = IDLE;
                        held_d  = 1'b0;
                        if (held_q) last_d = grant_q;
                    end
`else
                    state_d = IDLE;
`endif
                end else if (g_sel == '0) begin
                    ack  = 1'b1;
                    done = 1'b1;
                end else if (g_we) begin
                    wr_en = 1'b1;
                    ack   = 1'b1;
                    done  = 1'b1;
                end else begin
                    rd_en   = 1'b1;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                ack  = g_req;
                done = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
`ifdef WB_SRAM_ARB_BURST_EN
            if (g_cyc) begin
                state_d = ACCESS;
                held_d  = 1'b1;
            end else begin
                state_d = IDLE;
                last_d  = grant_q;
                held_d  = 1'b0;
            end
`else
            state_d = IDLE;
            last_d  = grant_q;
`endif
        end

        // A transfer caught by reset must not be acknowledged at the reset edge.
        if (!rstn) begin
            ack   = 1'b0;
            rd_en = 1'b0;
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
`ifdef WB_SRAM_ARB_BURST_EN
            held_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef WB_SRAM_ARB_BURST_EN
            held_q  <= held_d;
`endif
        end
    end

    assign sram_read_en  = rd_en;
    assign sram_write_en = wr_en;
    assign m0_ack        = ack & ~grant_q;
    assign m1_ack        = ack &  grant_q;
    assign m0_dat_r      = sram_read_data;
    assign m1_dat_r      = sram_read_data;
    assign m0_err        = 1'b0;
    assign m1_err        = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_wb_sram_arbiter_2m.sv
// ============================================================================
// Module      : tb_wb_sram_arbiter_2m
// Description : Directed self-checking bench for wb_sram_arbiter_2m.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_sram_arbiter_2m;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_adr, m1_adr, m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] sram_addr, sram_write_data;
    logic [31:0] sram_read_data = 32'h0;
    logic        sram_read_en, sram_write_en;
    logic [3:0]  sram_byte_en;

    logic [31:0] mem [64];
    logic        init_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_sram_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .m0_cyc          (m0_cyc),
        .m0_stb          (m0_stb),
        .m0_we           (m0_we),
        .m0_adr          (m0_adr),
        .m0_sel          (m0_sel),
        .m0_dat_w        (m0_dat_w),
        .m0_dat_r        (m0_dat_r),
        .m0_ack          (m0_ack),
        .m0_err          (m0_err),
        .m1_cyc          (m1_cyc),
        .m1_stb          (m1_stb),
        .m1_we           (m1_we),
        .m1_adr          (m1_adr),
        .m1_sel          (m1_sel),
        .m1_dat_w        (m1_dat_w),
        .m1_dat_r        (m1_dat_r),
        .m1_ack          (m1_ack),
        .m1_err          (m1_err),
        .sram_addr       (sram_addr),
        .sram_read_en    (sram_read_en),
        .sram_write_en   (sram_write_en),
        .sram_byte_en    (sram_byte_en),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data)
    );

    // SRAM model: word i starts as A5A5_00ii except word 8 (address 0x20).
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= (i == 8) ? 32'hCAFE_F00D : (32'hA5A5_0000 + 32'(i));
            init_done <= 1'b1;
        end else begin
            if (sram_write_en)
                for (int b = 0; b < 4; b++)
                    if (sram_byte_en[b]) mem[sram_addr[7:2]][8*b +: 8] <= sram_write_data[8*b +: 8];
            if (sram_read_en)
                sram_read_data <= mem[sram_addr[7:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic m0_drive(input logic req, input logic we, input logic [31:0] adr,
                            input logic [3:0] sel, input logic [31:0] dat);
        m0_cyc = req; m0_stb = req; m0_we = we; m0_adr = adr; m0_sel = sel; m0_dat_w = dat;
    endtask

    task automatic m1_drive(input logic req, input logic we, input logic [31:0] adr,
                            input logic [3:0] sel, input logic [31:0] dat);
        m1_cyc = req; m1_stb = req; m1_we = we; m1_adr = adr; m1_sel = sel; m1_dat_w = dat;
    endtask

    initial begin
        int n0, n1, total;
        logic exp_who;

        rstn = 1'b0;
        m0_drive(1'b0, 1'b0, 32'h44, 4'h0, 32'h0);
        m1_drive(1'b0, 1'b0, 32'h88, 4'h0, 32'h0);

        // ---- reset state
        tick; tick; #1;
        check("rst_m0_ack", {31'b0, m0_ack}, 32'h0);
        check("rst_m1_ack", {31'b0, m1_ack}, 32'h0);
        check("rst_strobes", {30'b0, sram_read_en, sram_write_en}, 32'h0);
        check("rst_err", {30'b0, m0_err, m1_err}, 32'h0);
        check("rst_addr_m0", sram_addr, 32'h44);
        rstn = 1'b1;
        tick;

        // ---- single write from m0
        m0_drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        #1;
        check("wr_c1_we", {31'b0, sram_write_en}, 32'h0);
        check("wr_c1_ack", {31'b0, m0_ack}, 32'h0);
        tick; #1;
        check("wr_c2_we", {31'b0, sram_write_en}, 32'h1);
        check("wr_c2_be", {28'b0, sram_byte_en}, 32'hF);
        check("wr_c2_addr", sram_addr, 32'h10);
        check("wr_c2_data", sram_write_data, 32'hDEAD_BEEF);
        check("wr_c2_ack", {31'b0, m0_ack}, 32'h1);
        tick;
        m0_drive(1'b0, 1'b0, 32'h44, 4'h0, 32'h0);
        #1;
        check("wr_c3_we", {31'b0, sram_write_en}, 32'h0);
        check("wr_mem", mem[4], 32'hDEAD_BEEF);
        tick;

        // ---- read from m1
        m1_drive(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        #1;
        check("rd_c1_re", {31'b0, sram_read_en}, 32'h0);
        tick; #1;
        check("rd_c2_re", {31'b0, sram_read_en}, 32'h1);
        check("rd_c2_addr", sram_addr, 32'h20);
        check("rd_c2_ack", {31'b0, m1_ack}, 32'h0);
        tick; #1;
        check("rd_c3_ack", {31'b0, m1_ack}, 32'h1);
        check("rd_c3_data", m1_dat_r, 32'hCAFE_F00D);
        check("rd_c3_m0ack", {31'b0, m0_ack}, 32'h0);
        tick;
        m1_drive(1'b0, 1'b0, 32'h88, 4'h0, 32'h0);
        tick;

        // ---- zero byte select from m0
        m0_drive(1'b1, 1'b1, 32'h30, 4'h0, 32'h1234_5678);
        #1;
        check("zs_c1_ack", {31'b0, m0_ack}, 32'h0);
        tick; #1;
        check("zs_c2_ack", {31'b0, m0_ack}, 32'h1);
        check("zs_c2_strobes", {30'b0, sram_read_en, sram_write_en}, 32'h0);
        tick;
        m0_drive(1'b0, 1'b0, 32'h44, 4'h0, 32'h0);
        #1;
        check("zs_c3_strobes", {30'b0, sram_read_en, sram_write_en}, 32'h0);
        tick; #1;
        check("zs_mem", mem[12], 32'hA5A5_000C);

        // ---- reset during RDATA of an m1 read
        m1_drive(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        tick; #1;
        check("rr_c2_re", {31'b0, sram_read_en}, 32'h1);
        tick;
        rstn = 1'b0;
        #1;
        check("rr_rdata_ack", {31'b0, m1_ack}, 32'h0);
        tick; #1;
        check("rr_rst_ack", {30'b0, m0_ack, m1_ack}, 32'h0);
        check("rr_rst_strobes", {30'b0, sram_read_en, sram_write_en}, 32'h0);
        check("rr_rst_addr", sram_addr, 32'h44);
        rstn = 1'b1;
        #1;
        check("rr_after_c1_re", {31'b0, sram_read_en}, 32'h0);
        tick; #1;
        check("rr_after_c2_re", {31'b0, sram_read_en}, 32'h1);
        tick; #1;
        check("rr_after_c3_ack", {31'b0, m1_ack}, 32'h1);
        check("rr_after_c3_data", m1_dat_r, 32'hCAFE_F00D);
        tick;
        m1_drive(1'b0, 1'b0, 32'h88, 4'h0, 32'h0);
        tick;

`ifndef WB_SRAM_ARB_BURST_EN
        // ---- contention: both masters read continuously, 8 transfers
        m0_drive(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
        m1_drive(1'b1, 1'b0, 32'h44, 4'hF, 32'h0);
        n0 = 0; n1 = 0; total = 0; exp_who = 1'b0;
        #1;
        for (int c = 0; c < 40 && total < 8; c++) begin
            if (m0_ack | m1_ack) begin
                check("ct_overlap", {31'b0, m0_ack & m1_ack}, 32'h0);
                check("ct_order", {31'b0, m1_ack}, {31'b0, exp_who});
                check("ct_data", m1_ack ? m1_dat_r : m0_dat_r,
                      exp_who ? 32'hA5A5_0011 : 32'hA5A5_0010);
                if (m0_ack) n0++;
                if (m1_ack) n1++;
                exp_who = ~exp_who;
                total++;
            end
            tick; #1;
        end
        m0_drive(1'b0, 1'b0, 32'h44, 4'h0, 32'h0);
        m1_drive(1'b0, 1'b0, 32'h88, 4'h0, 32'h0);
        check("ct_total", total, 32'd8);
        check("ct_m0_acks", n0, 32'd4);
        check("ct_m1_acks", n1, 32'd4);
        tick;

        // ---- back-to-back writes from one master leave one idle bubble
        m0_drive(1'b1, 1'b1, 32'h50, 4'h3, 32'h0000_BEEF);
        #1;
        check("bb_c1_ack", {31'b0, m0_ack}, 32'h0);
        tick; #1;
        check("bb_c2_ack", {31'b0, m0_ack}, 32'h1);
        check("bb_c2_be", {28'b0, sram_byte_en}, 32'h3);
        tick; #1;
        check("bb_c3_bubble", {30'b0, m0_ack, sram_write_en}, 32'h0);
        tick; #1;
        check("bb_c4_ack", {31'b0, m0_ack}, 32'h1);
        tick;
        m0_drive(1'b0, 1'b0, 32'h44, 4'h0, 32'h0);
        #1;
        check("bb_mem", mem[20], 32'hA5A5_BEEF);
`else
        // ---- burst: m0 holds cyc for 4 writes while m1 waits
        m1_drive(1'b1, 1'b1, 32'h60, 4'hF, 32'h1111_2222);
        m0_drive(1'b1, 1'b1, 32'h50, 4'hF, 32'hB000_0000);
        #1;
        check("bu_c1_ack", {30'b0, m0_ack, m1_ack}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick; #1;
            check("bu_m0_ack", {31'b0, m0_ack}, 32'h1);
            check("bu_m1_ack", {31'b0, m1_ack}, 32'h0);
            check("bu_we", {31'b0, sram_write_en}, 32'h1);
            check("bu_addr", sram_addr, 32'h50 + 32'(4 * k));
            if (k < 3) m0_drive(1'b1, 1'b1, 32'h54 + 32'(4 * k), 4'hF, 32'hB000_0001 + 32'(k));
            else       m0_drive(1'b0, 1'b0, 32'h44, 4'h0, 32'h0);
        end
        tick; #1;
        check("bu_idle_ack", {30'b0, m0_ack, m1_ack}, 32'h0);
        tick; #1;
        check("bu_m1_granted", {31'b0, m1_ack}, 32'h1);
        check("bu_m1_addr", sram_addr, 32'h60);
        tick;
        m1_drive(1'b0, 1'b0, 32'h88, 4'h0, 32'h0);
        #1;
        check("bu_mem_m0", mem[23], 32'hB000_0003);
        check("bu_mem_m1", mem[24], 32'h1111_2222);
        n0 = 0; n1 = 0; total = 0; exp_who = 1'b0;
`endif
        tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_sram_arbiter_2m.md
Name: wb_sram_arbiter_2m

Overview:
- Two-master Wishbone arbiter in front of one single-port generic byte-enable SRAM.
- Lets two bus masters (e.g. CPU and DMA) share one SRAM.
- Round-robin grant, one transfer in flight; sequences the SRAM's 1-cycle synchronous read latency.
- Drives the SRAM client signals directly; no separate bridge instance needed.

Parameters:
- ADDR_WIDTH, 32, width of Wishbone ADR and of sram_addr (passed through unmodified).
- DATA_WIDTH, 32, data width; must be a multiple of 8; byte lanes NB = DATA_WIDTH/8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- mN_cyc, mN_stb, mN_we  in  1 each  Wishbone cycle/strobe/write-enable, master N (N=0,1).
- mN_adr  in  ADDR_WIDTH  address, master N.
- mN_sel  in  NB  byte select, master N.
- mN_dat_w  in  DATA_WIDTH  write data, master N.
- mN_dat_r  out  DATA_WIDTH  read data, master N; equals sram_read_data, meaningful only with mN_ack.
- mN_ack  out  1  acknowledge, master N.
- mN_err  out  1  error, master N; constant 0.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_read_en  out  1  SRAM read strobe.
- sram_write_en  out  1  SRAM write strobe.
- sram_byte_en  out  NB  SRAM byte enables.
- sram_write_data  out  DATA_WIDTH  SRAM write data.
- sram_read_data  in  DATA_WIDTH  SRAM read data; valid the cycle after sram_read_en.

Behaviour:
- Request: reqN = mN_cyc & mN_stb.
- Registered state: FSM {IDLE, ACCESS, RDATA}, grant (1 bit), last (1 bit, master last served).
- Reset: state=IDLE, grant=0, last=1 (master 0 preferred first).
  - All mN_ack=0, sram_read_en=0, sram_write_en=0.
  - sram_addr, sram_byte_en, sram_write_data follow master 0 (grant=0).
  - mN_err=0 always.
- IDLE:
  - No SRAM strobes, no acks.
  - If any reqN: grant <= requester; if both request, grant <= ~last. Go to ACCESS.
- ACCESS: sram_addr/byte_en/write_data mux from the granted master.
  - Granted req low (master abandoned): no strobes, no ack, go to IDLE, last unchanged.
  - Granted mN_sel==0: no strobes; mN_ack=1 this cycle; last<=grant; go to IDLE.
  - Write: sram_write_en=1, sram_byte_en=mN_sel; mN_ack=1 combinationally this cycle; last<=grant; go to IDLE.
  - Read: sram_read_en=1, go to RDATA.
- RDATA:
  - mN_ack = mN_cyc & mN_stb of the granted master; mN_dat_r = sram_read_data.
  - last<=grant; go to IDLE.
- Latency from IDLE with the request present:
  - Write: ack in cycle 2 (request seen cycle 1).
  - Read: ack in cycle 3.
  - Without the optional feature, back-to-back transfers from one master have one idle bubble between them.
- The non-granted master's ack is always 0; its request is held off until a later IDLE.
- Simultaneous requests every cycle: grants strictly alternate 0,1,0,1.
- Grant changes only in IDLE; inputs of the non-granted master never reach the SRAM.
- Reset mid-operation (including RDATA): return to reset state next edge; the pending read is never acked.

Optional Feature:
- Macro WB_SRAM_ARB_BURST_EN.
- Defined:
  - On completing a transfer (write/zero-SEL ack in ACCESS, or read ack in RDATA), if the granted master's mN_cyc stays high, go straight to ACCESS with the same grant instead of IDLE.
  - last is not updated while the grant is held.
  - Grant releases only when the granted master drops cyc; the other master waits for the whole burst.
  - Each transfer is still acked only once stb is seen in ACCESS.
- Undefined: behaviour exactly as above; every completion returns to IDLE.

Decomposition:
- Package wb_sram_arb_pkg holds:
  - arb_state_e enum {IDLE, ACCESS, RDATA}.
  - Localparam helper for NB.
- One natural sub-module: wb_rr_arb2, a 2-requester round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational; reused by other arbiters.

Test Plan:
- Single write: m0 writes adr=0x10, sel=0xF, dat=0xDEADBEEF.
  - sram_write_en=1 for exactly one cycle with byte_en=0xF; m0_ack in that same cycle, cycle 2 after request.
- Read latency: preload 0xCAFEF00D at 0x20; m1 reads 0x20.
  - sram_read_en in cycle 2; m1_ack=1 with m1_dat_r=0xCAFEF00D in cycle 3; m0_ack stays 0.
- Contention: both masters hold reads continuously for 8 transfers.
  - Grants 0,1,0,1,...; each master receives exactly 4 acks; no overlapping acks.
- Zero-byte-select: m0 writes sel=0x0.
  - m0_ack asserted; sram_write_en and sram_read_en never asserted; memory unchanged.
- Reset during RDATA: drop rstn in the RDATA cycle.
  - No ack is issued; next cycle all outputs are at reset values; a subsequent m1-only request is served normally.
- With WB_SRAM_ARB_BURST_EN: m0 keeps cyc high for 4 writes while m1 also requests.
  - m0 gets 4 consecutive ACCESS cycles with no IDLE between them; m1 is granted only after m0 drops cyc.
